// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, default width/iteration count, divide-by-zero quotient.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_DEF  = 32;

    typedef enum logic [1:0] {
        OP_MULLO = 2'b00,
        OP_MULHI = 2'b01,
        OP_DIVQ  = 2'b10,
        OP_DIVR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } state_e;

    localparam logic [WIDTH_DEF-1:0] DIV0_Q = '1;

endpackage

// File: rtl/muldiv_if.sv
// Issue/write-back bundle between the controller, the muldiv unit and the
// register file write port.
interface muldiv_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [5:0]  dest;
    logic        busy;
    logic        done;
    logic        RegWrite;
    logic [5:0]  WriteReg;
    logic [31:0] WriteData;

    modport master (
        output start, op, src_a, src_b, dest,
        input  busy, done, RegWrite, WriteReg, WriteData
    );

    modport slave (
        input  start, op, src_a, src_b, dest,
        output busy, done, RegWrite, WriteReg, WriteData
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration over a {high, low} accumulator: add-and-shift-right
// for multiply, trial-subtract-and-shift-left (restoring) for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               is_div,
    input  logic [WIDTH-1:0]   operand,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Partial remainder after shifting in the next dividend bit; the
        // extra top bit is needed because it can exceed WIDTH bits briefly.
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        fits      = (rem_shift >= {1'b0, operand});
        rem_sub   = rem_shift[WIDTH-1:0] - operand;
        if (!is_div) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (fits) begin
            acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply/divide stage with a registered
// single-cycle register-file write-back and start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input logic     clock,
    input logic     reset,
    muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(ITER);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    op_e                op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [5:0]         dest_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   result;
    logic               is_div;
    logic               done_q;
    logic               regwrite_q;
    logic [5:0]         writereg_q;
    logic [WIDTH-1:0]   writedata_q;

    assign is_div = (op_q == OP_DIVQ) || (op_q == OP_DIVR);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .operand  (opnd_q),
        .acc      (acc),
        .acc_next (acc_next)
    );

    // Result is taken from the final step's output so it can be registered
    // on the same edge that enters WB. A zero divisor already leaves the
    // dividend in the remainder half; the quotient is forced explicitly.
    always_comb begin
        case (op_q)
            OP_MULLO: result = acc_next[WIDTH-1:0];
            OP_MULHI: result = acc_next[2*WIDTH-1:WIDTH];
            OP_DIVQ:  result = (opnd_q == '0) ? DIV0_Q : acc_next[WIDTH-1:0];
            default:  result = acc_next[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= OP_MULLO;
            opnd_q      <= '0;
            dest_q      <= '0;
            acc         <= '0;
            done_q      <= 1'b0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            done_q     <= 1'b0;
            regwrite_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= op_e'(bus.op);
                        opnd_q <= bus.src_b;
                        dest_q <= bus.dest;
                        acc    <= {{WIDTH{1'b0}}, bus.src_a};
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state       <= WB;
                        done_q      <= 1'b1;
                        regwrite_q  <= (dest_q != '0);
                        writereg_q  <= dest_q;
                        writedata_q <= result;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.RegWrite  = regwrite_q;
    assign bus.WriteReg  = writereg_q;
    assign bus.WriteData = writedata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs,
// a negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    muldiv_if bus();

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  dest;
        logic [31:0] data;
        logic        wr;
    } exp_t;

    exp_t sbq[$];
    int   accepts[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_acc = 0;
    logic busy_d   = 1'b0;
    logic done_d   = 1'b0;
    exp_t mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: plain 64-bit arithmetic and the documented divide-by-zero rule.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            busy_d = 1'b0;
            done_d = 1'b0;
        end else begin
            if (bus.busy && !busy_d) begin
                accepts.push_back(cyc);
                last_acc = cyc;
            end
            check("regwrite_outside_wb", bus.RegWrite & ~bus.done, 0);
            if (bus.done) begin
                done_cnt++;
                check("done_single_pulse", done_d, 0);
                if (sbq.size() == 0) begin
                    timeout_fail("unexpected_done");
                end else begin
                    mon_e = sbq.pop_front();
                    check("WriteReg", bus.WriteReg, mon_e.dest);
                    check("WriteData", bus.WriteData, mon_e.data);
                    check("RegWrite", bus.RegWrite, mon_e.wr);
                    check("latency", cyc - last_acc + 1, 33);
                end
            end
            busy_d = bus.busy;
            done_d = bus.done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (bus.busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timeout_fail("idle_wait");
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] d);
        int n = 0;
        @(negedge clock);
        while (bus.busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timeout_fail("issue_wait");
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.dest  = d;
        sbq.push_back('{dest: d, data: model(op, a, b), wr: (d != 0)});
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.dest  = 6'($urandom);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] d);
        issue(op, a, b, d);
        wait_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        int n0;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.dest  = '0;

        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_RegWrite", bus.RegWrite, 0);
        check("rst_WriteReg", bus.WriteReg, 0);
        check("rst_WriteData", bus.WriteData, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run(OP_MULLO, 32'd7, 32'd6, 6'd5);
        run(OP_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1);
        run(OP_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2);
        run(OP_DIVQ, 32'd100, 32'd7, 6'd3);
        run(OP_DIVR, 32'd100, 32'd7, 6'd4);
        run(OP_DIVQ, 32'd100, 32'd0, 6'd6);
        run(OP_DIVR, 32'd100, 32'd0, 6'd7);
        run(OP_MULLO, 32'd3, 32'd3, 6'd0);

        // Start pulses during an operation must be dropped, not queued.
        d0 = done_cnt;
        issue(OP_MULLO, 32'd11, 32'd13, 6'd9);
        repeat (4) @(negedge clock);
        bus.start = 1'b1; bus.op = OP_DIVQ; bus.src_a = 32'd999; bus.src_b = 32'd3; bus.dest = 6'd12;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (14) @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULHI; bus.src_a = 32'd5; bus.src_b = 32'd77; bus.dest = 6'd13;
        @(negedge clock);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);
        check("ignored_start_writes", done_cnt - d0, 1);
        check("ignored_start_idle", bus.busy, 0);

        // Asynchronous reset mid-operation discards the operation.
        issue(OP_DIVQ, $urandom, 32'd17, 6'd20);
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_RegWrite", bus.RegWrite, 0);
        check("midrst_WriteReg", bus.WriteReg, 0);
        check("midrst_WriteData", bus.WriteData, 0);
        sbq.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        run(OP_DIVR, 32'd12345, 32'd100, 6'd21);
        check("post_reset_writes", done_cnt - d0, 1);

        for (int i = 0; i < 14; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            run(2'($urandom), ra, rb, 6'($urandom_range(0, 63)));
        end

        // Start held high: a new operation is accepted every 34 cycles.
        n0 = accepts.size();
        ra = $urandom;
        rb = $urandom;
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULHI; bus.src_a = ra; bus.src_b = rb; bus.dest = 6'd30;
        sbq.push_back('{dest: 6'd30, data: model(OP_MULHI, ra, rb), wr: 1'b1});
        sbq.push_back('{dest: 6'd30, data: model(OP_MULHI, ra, rb), wr: 1'b1});
        n = 0;
        while (accepts.size() < n0 + 2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        bus.start = 1'b0;
        if (n >= 200) timeout_fail("b2b_accept");
        else check("b2b_interval", accepts[n0 + 1] - accepts[n0], 34);
        wait_idle();

        repeat (5) @(negedge clock);
        check("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
